hog_block_stream: RTL and testbench
===================================

Name: hog_block_stream

Overview:
Parametrised successor to the fixed-geometry HOG block gatherer. It takes a raster-order stream of cell histograms and buffers one cell row internally. For every 2x2 cell neighbourhood it emits one block: the four cell histograms, the block id, an end-of-frame flag and the block's L1 bin sum. It sits between the cell histogram stage and the normalizer, with full valid/ready backpressure on both sides.

Parameters:
NBINS, 9, bins per cell histogram
BIN_W, 32, bin width (unsigned 16.16 fixed point)
CELLS_X, 40, cells per row (>=2)
CELLS_Y, 30, cell rows per frame (>=2)
BID_W, 13, block id width; must satisfy 2^BID_W >= (CELLS_X-1)*(CELLS_Y-1)
SUM_W (localparam), BIN_W + clog2(4*NBINS), width of the L1 sum

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
i_bin  in  NBINS*BIN_W  cell histogram; bin 0 in the LSBs
i_sof  in  1  marks the first cell of a frame; qualified by i_valid
i_valid  in  1  input cell valid
i_ready  out  1  input accept
o_cell_a  out  NBINS*BIN_W  above-left cell
o_cell_b  out  NBINS*BIN_W  above cell
o_cell_c  out  NBINS*BIN_W  left cell
o_cell_d  out  NBINS*BIN_W  current cell
o_sum  out  SUM_W  unsigned sum of all 4*NBINS bins of the block
o_bid  out  BID_W  block id, raster order from 0
o_eof  out  1  asserted with the last block of a frame
o_valid  out  1  output block valid
o_ready  in  1  downstream accept

Behaviour:
- A cell is accepted when i_valid && i_ready. i_ready = !o_valid || o_ready (single output register; combinational path from o_ready).
- Counters col (0..CELLS_X-1) and row (0..CELLS_Y-1) advance on each accepted cell.
- Line buffer: CELLS_X-entry register array with combinational read. On accepting a cell at column col, the buffer reads entry col, which holds the above cell, and then overwrites that entry with the new cell. A left-cell register holds the previously accepted cell. An above-left register holds the previous buffer read.
- Block emission: an accepted cell with row>=1 and col>=1 loads the output register on the next edge and sets o_valid. Latency is 1 cycle. The loaded values are:
  - a = above-left, b = above, c = left, d = current
  - bid = (row-1)*(CELLS_X-1) + (col-1)
  - o_eof = (row==CELLS_Y-1 && col==CELLS_X-1)
  - o_sum = full-precision sum, no overflow possible by the SUM_W definition.
- Cells in row 0 or column 0 only update storage and produce no block.
- o_valid clears when o_valid && o_ready and no new block loads in the same cycle. If a block is consumed and a new one loads on the same edge, o_valid stays 1.
- While o_valid && !o_ready, every output is held stable and no cell is accepted.
- Wrap-around: after cell (CELLS_Y-1, CELLS_X-1), col and row return to 0. The next cell starts a new frame whether or not i_sof is asserted.
- i_sof on an accepted cell forces that cell to position (0,0).
  - If this happens mid-frame, the partial frame is abandoned and no o_eof is generated for it.
  - An already-registered output block is still delivered normally.
- i_sof without i_valid is ignored.
- Reset (asynchronous assert, synchronous deassert):
  - o_valid, o_eof, o_bid, o_sum and all o_cell_* go to 0.
  - Counters and the left/above-left registers go to 0.
  - Line buffer contents are don't-care; they are never emitted before being rewritten.
  - i_ready = 1 after reset.
  - Reset mid-frame discards any pending block.

Test Plan:
Bench parameters: CELLS_X=4, CELLS_Y=3, NBINS=2, BIN_W=8, SUM_W=11.
- Basic frame: stream cells k=0..11, each bin = k, i_sof on k=0, o_ready=1 -> exactly 6 blocks.
  - First block: a=0, b=1, c=4, d=5, bid=0, sum=20, 1 cycle after cell 5.
  - Last block: a=6, b=7, c=10, d=11, bid=5, sum=68, o_eof=1.
- Backpressure: hold o_ready=0 for 3 cycles while o_valid=1 -> outputs stable, i_ready=0. After release, all 6 blocks arrive in order with no loss or duplication.
- Mid-frame restart: i_sof asserted on the 7th cell (new cell value 100) -> no o_eof for the abandoned frame. The next block appears after 5 more cells with bid=0 and a=100.
- Back-to-back frames, no second i_sof -> second frame blocks carry bid 0..5, with o_eof on each frame's bid 5.
- Max sum: all bins 255 -> o_sum=2040 with no wrap.
- Reset: assert rst low mid-frame with o_valid=1 -> o_valid and all outputs 0 immediately (before the next clk edge). After release, a fresh frame behaves as in the basic-frame scenario.

Source files
------------

// File: rtl/hog_block_stream_if.sv
// hog_block_stream_if: handshake bundle for the HOG block gatherer.
//   Cell side  : i_bin, i_sof, i_valid (to gatherer), i_ready (from gatherer)
//   Block side : o_cell_a..d, o_sum, o_bid, o_eof, o_valid (from gatherer),
//                o_ready (to gatherer)
//   master : the environment (cell producer + block consumer)
//   slave  : the gatherer
interface hog_block_stream_if #(
  parameter int NBINS = 9,
  parameter int BIN_W = 32,
  parameter int BID_W = 13
);
  localparam int CELL_W = NBINS * BIN_W;
  localparam int SUM_W  = BIN_W + $clog2(4 * NBINS);

  logic [CELL_W-1:0] i_bin;
  logic              i_sof;
  logic              i_valid;
  logic              i_ready;
  logic [CELL_W-1:0] o_cell_a;
  logic [CELL_W-1:0] o_cell_b;
  logic [CELL_W-1:0] o_cell_c;
  logic [CELL_W-1:0] o_cell_d;
  logic [SUM_W-1:0]  o_sum;
  logic [BID_W-1:0]  o_bid;
  logic              o_eof;
  logic              o_valid;
  logic              o_ready;

  modport master (
    output i_bin, i_sof, i_valid, o_ready,
    input  i_ready, o_cell_a, o_cell_b, o_cell_c, o_cell_d,
           o_sum, o_bid, o_eof, o_valid
  );

  modport slave (
    input  i_bin, i_sof, i_valid, o_ready,
    output i_ready, o_cell_a, o_cell_b, o_cell_c, o_cell_d,
           o_sum, o_bid, o_eof, o_valid
  );
endinterface

// File: rtl/hog_block_stream.sv
// hog_block_stream: gathers 2x2 cell neighbourhoods from a raster-order
// stream of cell histograms and emits one block per neighbourhood.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : hog_block_stream_if.slave
//          cell in  : i_bin (bin 0 in LSBs), i_sof, i_valid / i_ready
//          block out: o_cell_a (above-left), o_cell_b (above), o_cell_c (left),
//                     o_cell_d (current), o_sum (L1 sum), o_bid, o_eof,
//                     o_valid / o_ready
module hog_block_stream #(
  parameter int NBINS   = 9,
  parameter int BIN_W   = 32,
  parameter int CELLS_X = 40,
  parameter int CELLS_Y = 30,
  parameter int BID_W   = 13
) (
  input logic               clk,
  input logic               rst,
  hog_block_stream_if.slave bus
);
  localparam int CELL_W = NBINS * BIN_W;
  localparam int SUM_W  = BIN_W + $clog2(4 * NBINS);
  localparam int COL_W  = $clog2(CELLS_X);
  localparam int ROW_W  = $clog2(CELLS_Y);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(CELLS_X - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CELLS_Y - 1);

  logic [CELL_W-1:0] line_buf [CELLS_X];
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [CELL_W-1:0] left_q;
  logic [CELL_W-1:0] above_left_q;

  logic [CELL_W-1:0] a_q, b_q, c_q, d_q;
  logic [SUM_W-1:0]  sum_q;
  logic [BID_W-1:0]  bid_q;
  logic              eof_q;
  logic              valid_q;

  logic              in_ready;
  logic              accept;
  logic [COL_W-1:0]  pos_col;
  logic [ROW_W-1:0]  pos_row;
  logic [COL_W-1:0]  nxt_col;
  logic [ROW_W-1:0]  nxt_row;
  logic [CELL_W-1:0] above;
  logic              emit;
  logic              at_eof;
  logic [SUM_W-1:0]  block_sum;
  logic [BID_W-1:0]  block_bid;

  assign in_ready = !valid_q || bus.o_ready;

  always_comb begin
    accept  = bus.i_valid && in_ready;
    // An accepted i_sof relocates the current cell to (0,0) before any use.
    pos_col = bus.i_sof ? '0 : col;
    pos_row = bus.i_sof ? '0 : row;
    above   = line_buf[pos_col];
    emit    = accept && (pos_row != '0) && (pos_col != '0);
    at_eof  = (pos_row == LAST_ROW) && (pos_col == LAST_COL);

    if (pos_col == LAST_COL) begin
      nxt_col = '0;
      nxt_row = (pos_row == LAST_ROW) ? '0 : pos_row + ROW_W'(1);
    end else begin
      nxt_col = pos_col + COL_W'(1);
      nxt_row = pos_row;
    end

    block_bid = BID_W'((int'(pos_row) - 1) * (CELLS_X - 1) + (int'(pos_col) - 1));

    block_sum = '0;
    for (int unsigned i = 0; i < NBINS; i++) begin
      block_sum = block_sum
                + SUM_W'(above_left_q[i*BIN_W +: BIN_W])
                + SUM_W'(above[i*BIN_W +: BIN_W])
                + SUM_W'(left_q[i*BIN_W +: BIN_W])
                + SUM_W'(bus.i_bin[i*BIN_W +: BIN_W]);
    end
  end

  // Line buffer has no reset: every entry is rewritten in row 0 before it
  // can be read as an "above" cell of an emitted block.
  always_ff @(posedge clk) begin
    if (accept) line_buf[pos_col] <= bus.i_bin;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col          <= '0;
      row          <= '0;
      left_q       <= '0;
      above_left_q <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      d_q          <= '0;
      sum_q        <= '0;
      bid_q        <= '0;
      eof_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      if (accept) begin
        col          <= nxt_col;
        row          <= nxt_row;
        left_q       <= bus.i_bin;
        above_left_q <= above;
      end
      if (emit) begin
        a_q     <= above_left_q;
        b_q     <= above;
        c_q     <= left_q;
        d_q     <= bus.i_bin;
        sum_q   <= block_sum;
        bid_q   <= block_bid;
        eof_q   <= at_eof;
        valid_q <= 1'b1;
      end else if (bus.o_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.i_ready  = in_ready;
  assign bus.o_cell_a = a_q;
  assign bus.o_cell_b = b_q;
  assign bus.o_cell_c = c_q;
  assign bus.o_cell_d = d_q;
  assign bus.o_sum    = sum_q;
  assign bus.o_bid    = bid_q;
  assign bus.o_eof    = eof_q;
  assign bus.o_valid  = valid_q;
endmodule

// File: tb/tb_hog_block_stream.sv
// tb_hog_block_stream: scoreboard bench for hog_block_stream with a
// 4x3-cell frame of 2-bin, 8-bit histograms.
module tb_hog_block_stream;
  localparam int NB = 2;
  localparam int BW = 8;
  localparam int CX = 4;
  localparam int CY = 3;
  localparam int BIDW = 4;

  typedef struct {
    logic [15:0] a, b, c, d;
    logic [3:0]  bid;
    logic        eof;
    logic [10:0] sum;
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hog_block_stream_if #(.NBINS(NB), .BIN_W(BW), .BID_W(BIDW)) bus ();

  hog_block_stream #(
    .NBINS(NB), .BIN_W(BW), .CELLS_X(CX), .CELLS_Y(CY), .BID_W(BIDW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;
  blk_t exp_q[$];
  blk_t got_q[$];
  logic [15:0] frame_mem [CY][CX];
  int pos_k = 0;
  int rdy_mode = 0;
  int phase = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int cell_sum(input logic [15:0] v);
    return int'(v[7:0]) + int'(v[15:8]);
  endfunction

  // Reference: remember every cell at its (row,col) of the current frame;
  // a cell with both neighbours above/left forms a block.
  function automatic bit model_cell(input logic [15:0] v, input bit sof);
    int rr, cc;
    blk_t e;
    bit em;
    if (sof) pos_k = 0;
    rr = pos_k / CX;
    cc = pos_k % CX;
    frame_mem[rr][cc] = v;
    em = (rr >= 1 && cc >= 1);
    if (em) begin
      e.a   = frame_mem[rr-1][cc-1];
      e.b   = frame_mem[rr-1][cc];
      e.c   = frame_mem[rr][cc-1];
      e.d   = v;
      e.bid = 4'((rr - 1) * (CX - 1) + (cc - 1));
      e.eof = (rr == CY - 1) && (cc == CX - 1);
      e.sum = 11'(cell_sum(e.a) + cell_sum(e.b) + cell_sum(e.c) + cell_sum(e.d));
      exp_q.push_back(e);
    end
    pos_k = (pos_k + 1) % (CX * CY);
    return em;
  endfunction

  task automatic send_cell(input logic [15:0] v, input bit sof);
    int waited;
    bit em;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_bin   = v;
    bus.i_sof   = sof;
    #1;
    waited = 0;
    while (!bus.i_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.i_ready) begin
      chk("accept_timeout", 32'(waited), 32'd0);
      bus.i_valid = 1'b0;
      return;
    end
    em = model_cell(v, sof);
    @(posedge clk);
    #1;
    if (em) begin
      chk("latency_valid", 32'(bus.o_valid), 32'd1);
      chk("latency_d", 32'(bus.o_cell_d), 32'(v));
    end
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'($urandom);
    bus.i_bin   = 16'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    idle(3);
  endtask

  // o_ready driver: 0 always ready, 1 random, 2 low 3 of every 5, 3 stalled.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       bus.o_ready = 1'b1;
      1:       bus.o_ready = 1'($urandom);
      2:       bus.o_ready = (phase % 5) >= 3;
      default: bus.o_ready = 1'b0;
    endcase
    phase++;
  end

  // Monitor: sampled mid-cycle; a handshake seen here completes on the next edge.
  initial begin
    blk_t h, e, g;
    bit hold;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", 32'(bus.o_valid), 32'd1);
          chk("hold_d", 32'(bus.o_cell_d), 32'(h.d));
          chk("hold_a", 32'(bus.o_cell_a), 32'(h.a));
          chk("hold_sum", 32'(bus.o_sum), 32'(h.sum));
          chk("hold_bid", 32'(bus.o_bid), 32'(h.bid));
        end
        hold = 1'b0;
        if (bus.o_valid && !bus.o_ready) begin
          chk("stall_i_ready", 32'(bus.i_ready), 32'd0);
          h.a = bus.o_cell_a; h.b = bus.o_cell_b; h.c = bus.o_cell_c; h.d = bus.o_cell_d;
          h.sum = bus.o_sum; h.bid = bus.o_bid; h.eof = bus.o_eof;
          hold = 1'b1;
        end else if (bus.o_valid && bus.o_ready) begin
          g.a = bus.o_cell_a; g.b = bus.o_cell_b; g.c = bus.o_cell_c; g.d = bus.o_cell_d;
          g.sum = bus.o_sum; g.bid = bus.o_bid; g.eof = bus.o_eof;
          got_q.push_back(g);
          if (exp_q.size() == 0) begin
            chk("unexpected_block", 32'(g.bid), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("blk_a", 32'(g.a), 32'(e.a));
            chk("blk_b", 32'(g.b), 32'(e.b));
            chk("blk_c", 32'(g.c), 32'(e.c));
            chk("blk_d", 32'(g.d), 32'(e.d));
            chk("blk_bid", 32'(g.bid), 32'(e.bid));
            chk("blk_eof", 32'(g.eof), 32'(e.eof));
            chk("blk_sum", 32'(g.sum), 32'(e.sum));
          end
        end
      end
    end
  end

  task automatic basic_frame();
    for (int k = 0; k < 12; k++) send_cell({8'(k), 8'(k)}, k == 0);
  endtask

  task automatic check_basic_ends(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'd6);
    if (got_q.size() == 6) begin
      chk({tag, "_first_a"}, 32'(got_q[0].a), 32'h0000);
      chk({tag, "_first_b"}, 32'(got_q[0].b), 32'h0101);
      chk({tag, "_first_c"}, 32'(got_q[0].c), 32'h0404);
      chk({tag, "_first_d"}, 32'(got_q[0].d), 32'h0505);
      chk({tag, "_first_bid"}, 32'(got_q[0].bid), 32'd0);
      chk({tag, "_first_sum"}, 32'(got_q[0].sum), 32'd20);
      chk({tag, "_last_a"}, 32'(got_q[5].a), 32'h0606);
      chk({tag, "_last_d"}, 32'(got_q[5].d), 32'h0b0b);
      chk({tag, "_last_bid"}, 32'(got_q[5].bid), 32'd5);
      chk({tag, "_last_sum"}, 32'(got_q[5].sum), 32'd68);
      chk({tag, "_last_eof"}, 32'(got_q[5].eof), 32'd1);
    end
  endtask

  function automatic int eof_count();
    int n;
    n = 0;
    foreach (got_q[i]) if (got_q[i].eof) n++;
    return n;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.i_bin   = '0;
    bus.o_ready = 1'b1;
    #12;
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_o_sum", 32'(bus.o_sum), 32'd0);
    chk("rst_o_bid", 32'(bus.o_bid), 32'd0);
    chk("rst_i_ready", 32'(bus.i_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Basic frame, always ready
    rdy_mode = 0;
    basic_frame();
    drain();
    check_basic_ends("basic");
    got_q.delete();

    // Periodic 3-cycle backpressure
    rdy_mode = 2;
    basic_frame();
    drain();
    check_basic_ends("bp");
    for (int i = 0; i < got_q.size(); i++) chk("bp_order", 32'(got_q[i].bid), 32'(i));
    got_q.delete();

    // Mid-frame restart on the 7th cell
    rdy_mode = 1;
    for (int k = 0; k < 6; k++) send_cell(16'($urandom), k == 0);
    send_cell({8'd100, 8'd100}, 1'b1);
    for (int k = 0; k < 11; k++) begin
      if ($urandom_range(0, 2) == 0) idle(1);
      send_cell(16'($urandom), 1'b0);
    end
    drain();
    chk("restart_count", 32'(got_q.size()), 32'd7);
    chk("restart_eofs", 32'(eof_count()), 32'd1);
    if (got_q.size() >= 2) begin
      chk("restart_first_eof", 32'(got_q[0].eof), 32'd0);
      chk("restart_bid", 32'(got_q[1].bid), 32'd0);
      chk("restart_a", 32'(got_q[1].a), 32'h6464);
    end
    got_q.delete();

    // Two frames back to back, i_sof only on the first
    for (int k = 0; k < 24; k++) send_cell(16'($urandom), k == 0);
    drain();
    chk("b2b_count", 32'(got_q.size()), 32'd12);
    chk("b2b_eofs", 32'(eof_count()), 32'd2);
    if (got_q.size() == 12) begin
      chk("b2b_eof1", 32'(got_q[5].eof), 32'd1);
      chk("b2b_bid6", 32'(got_q[6].bid), 32'd0);
      chk("b2b_eof2", 32'(got_q[11].eof), 32'd1);
    end
    got_q.delete();

    // Saturated bins
    rdy_mode = 0;
    for (int k = 0; k < 12; k++) send_cell(16'hFFFF, k == 0);
    drain();
    if (got_q.size() > 0) chk("max_sum", 32'(got_q[0].sum), 32'd2040);
    else chk("max_count", 32'(got_q.size()), 32'd6);
    got_q.delete();

    // Reset while a block is held
    rdy_mode = 3;
    for (int k = 0; k < 6; k++) send_cell({8'(k + 40), 8'(k + 40)}, k == 0);
    @(negedge clk);
    #3;
    chk("pre_rst_valid", 32'(bus.o_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    chk("mid_rst_a", 32'(bus.o_cell_a), 32'd0);
    chk("mid_rst_d", 32'(bus.o_cell_d), 32'd0);
    chk("mid_rst_sum", 32'(bus.o_sum), 32'd0);
    chk("mid_rst_bid", 32'(bus.o_bid), 32'd0);
    chk("mid_rst_i_ready", 32'(bus.i_ready), 32'd1);
    exp_q.delete();
    got_q.delete();
    pos_k = 0;
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    basic_frame();
    drain();
    check_basic_ends("post_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
